apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
//   Two-requester APB arbiter placed in front of the SPI subsystem top (apb_slave_mux + apb_spi_master).
//   Lets a CPU port (M0) and a DMA/sequencer port (M1) share one downstream APB completer port.
//   Grants round-robin, replays the winner's transfer downstream and stalls the loser via PREADY=0.
//   Routes PRDATA/PSLVERR back to the granted requester only.
// PARAMETERS
//   ADDR_W          32   address width of PADDR (all ports)
//   DATA_W          32   width of PWDATA/PRDATA (all ports)
//   TIMEOUT_CYCLES  256  ACCESS-phase watchdog limit; used only with APB_ARB_TIMEOUT_EN; must be >= 2
// PORTS
//   PCLK            in   1       single clock, all logic rising-edge
//   PRSTN           in   1       asynchronous active-low reset
//   Mx_DECODE2BIT   in   2       requester x (x=0,1) completer-select code, address-phase qualified
//   Mx_PADDR        in   ADDR_W  requester x address
//   Mx_PWRITE       in   1       requester x direction, 1=write
//   Mx_PSEL         in   1       requester x select
//   Mx_PENABLE      in   1       requester x enable (monitored only, not forwarded)
//   Mx_PWDATA       in   DATA_W  requester x write data
//   Mx_PRDATA       out  DATA_W  read data to requester x
//   Mx_PREADY       out  1       transfer complete to requester x
//   Mx_PSLVERR      out  1       error to requester x
//   DECODE2BIT      out  2       downstream completer-select code
//   PADDR/PWRITE/PWDATA out ADDR_W/1/DATA_W  downstream address phase, registered
//   PSEL/PENABLE    out  1/1     downstream select/enable, registered
//   PRDATA          in   DATA_W  downstream read data
//   PREADY/PSLVERR  in   1/1     downstream ready/error
// BEHAVIOUR
//   Reset: FSM=IDLE; PSEL=PENABLE=0; PADDR/PWDATA/DECODE2BIT/PWRITE=0; all Mx_PREADY/Mx_PSLVERR=0;
//     last_grant=1, so M0 has priority on the first arbitration. Reset mid-transfer drops it silently.
//   FSM states: IDLE -> SETUP -> ACCESS -> IDLE.
//   IDLE: if any Mx_PSEL=1, pick winner (both requesting: the one != last_grant).
//     Register winner's DECODE2BIT/PADDR/PWRITE/PWDATA.
//     Set PSEL=1, PENABLE=0 and grant=winner; go to SETUP.
//   SETUP: one cycle; next edge PENABLE=1, go to ACCESS.
//   ACCESS: hold all downstream outputs stable until PREADY=1.
//     On the PREADY=1 cycle: Mgrant_PREADY=1 (combinational from PREADY).
//     Mgrant_PRDATA=PRDATA, Mgrant_PSLVERR=PSLVERR on that same cycle.
//     At the edge: PSEL=PENABLE=0, last_grant=grant, go to IDLE.
//   Non-granted requester: Mx_PREADY=0, Mx_PSLVERR=0, Mx_PRDATA=0 at all times.
//   Min latency: Mx_PSEL rise -> Mx_PREADY = 3 cycles (IDLE, SETUP, ACCESS with zero-wait completer).
//   IDLE is always visited between transfers, giving 1 idle cycle downstream and a re-arbitration point.
//   Simultaneous request: alternates M0,M1,M0,... while both are held.
//   Single requester: granted back-to-back regardless of last_grant.
//   Requester drops PSEL before its PREADY (protocol violation): downstream transfer still completes.
//     The result is discarded and no PREADY is returned.
//   Request arriving during SETUP/ACCESS waits; it is sampled only in IDLE.
// CONFIGURATION
//   APB_ARB_TIMEOUT_EN defined:
//     Counter clears on SETUP->ACCESS and increments each ACCESS cycle with PREADY=0.
//     When it reaches TIMEOUT_CYCLES-1, the arbiter force-completes: Mgrant_PREADY=1, Mgrant_PSLVERR=1,
//       Mgrant_PRDATA=0; next edge PSEL=PENABLE=0 and IDLE.
//     Counter width = $clog2(TIMEOUT_CYCLES).
//   APB_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits on PREADY indefinitely.
// TESTING
//   M0 write 0x0000_0008<=0xA5 alone, zero-wait -> PSEL@+1, PENABLE@+2, M0_PREADY@+2; M1 sees PREADY=0.
//   M0 and M1 both read from reset, both held -> M0 served first, then M1, then M0; one IDLE cycle between.
//   M1 read, downstream PREADY low 5 cycles, PRDATA=0x1234_5678 -> M1_PREADY 1 cycle, M1_PRDATA=0x12345678.
//   Downstream PSLVERR=1 on M0 write -> M0_PSLVERR=1 with M0_PREADY only; no M1 output toggles.
//   PRSTN low in ACCESS -> PSEL/PENABLE/Mx_PREADY=0 asynchronously; after release M0 wins a tie.
//   APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY stuck 0 -> Mgrant_PREADY=Mgrant_PSLVERR=1 @16th ACCESS cycle.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-requester round-robin APB arbiter in front of one APB completer
//
// Purpose: lets a CPU requester (M0) and a DMA/sequencer requester (M1) share a
// single downstream APB completer. The winner's address phase is registered and
// replayed downstream; the loser sees PREADY=0 until it is served. Response
// signals go back to the granted requester only.
//
// Ports:
//   PCLK, PRSTN                      clock, asynchronous active-low reset
//   Mx_DECODE2BIT/PADDR/PWRITE/      requester x (x=0,1) APB request side
//   Mx_PSEL/PENABLE/PWDATA
//   Mx_PRDATA/PREADY/PSLVERR         requester x response side
//   DECODE2BIT/PADDR/PWRITE/PWDATA/  downstream request, all registered
//   PSEL/PENABLE
//   PRDATA/PREADY/PSLVERR            downstream response
//
// Optional feature: define APB_ARB_TIMEOUT_EN to enable an ACCESS-phase watchdog
// that force-completes a stalled transfer with PSLVERR=1 after TIMEOUT_CYCLES.
`timescale 1ns/1ps

module apb_master_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              PCLK,
  input  logic              PRSTN,
  input  logic [1:0]        M0_DECODE2BIT,
  input  logic [ADDR_W-1:0] M0_PADDR,
  input  logic              M0_PWRITE,
  input  logic              M0_PSEL,
  input  logic              M0_PENABLE,
  input  logic [DATA_W-1:0] M0_PWDATA,
  output logic [DATA_W-1:0] M0_PRDATA,
  output logic              M0_PREADY,
  output logic              M0_PSLVERR,
  input  logic [1:0]        M1_DECODE2BIT,
  input  logic [ADDR_W-1:0] M1_PADDR,
  input  logic              M1_PWRITE,
  input  logic              M1_PSEL,
  input  logic              M1_PENABLE,
  input  logic [DATA_W-1:0] M1_PWDATA,
  output logic [DATA_W-1:0] M1_PRDATA,
  output logic              M1_PREADY,
  output logic              M1_PSLVERR,
  output logic [1:0]        DECODE2BIT,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t r_state;
  state_t w_next;
  logic   r_grant;       // 0 = M0, 1 = M1
  logic   r_last_grant;  // reset to 1 so M0 wins the first tie
  logic   w_any_req;
  logic   w_winner;
  logic   w_timeout;
  logic   w_done;
  logic   w_rsp0;
  logic   w_rsp1;
  logic   w_unused;

  // Requester PENABLE is only observed; the downstream enable is generated here.
  assign w_unused  = M0_PENABLE ^ M1_PENABLE;

  assign w_any_req = M0_PSEL | M1_PSEL;
  // Tie goes to the requester not served last; otherwise the lone requester wins.
  assign w_winner  = (M0_PSEL & M1_PSEL) ? ~r_last_grant : M1_PSEL;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge PCLK or negedge PRSTN) begin
    if (!PRSTN) begin
      r_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_cnt <= '0;
    end else if (r_state == S_ACCESS && !PREADY && !w_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_ACCESS) && !PREADY &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_done = (r_state == S_ACCESS) && (PREADY || w_timeout);

  always_ff @(posedge PCLK or negedge PRSTN) begin
    if (!PRSTN) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_done) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRSTN) begin
    if (!PRSTN) begin
      DECODE2BIT   <= '0;
      PADDR        <= '0;
      PWRITE       <= 1'b0;
      PWDATA       <= '0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            DECODE2BIT <= w_winner ? M1_DECODE2BIT : M0_DECODE2BIT;
            PADDR      <= w_winner ? M1_PADDR      : M0_PADDR;
            PWRITE     <= w_winner ? M1_PWRITE     : M0_PWRITE;
            PWDATA     <= w_winner ? M1_PWDATA     : M0_PWDATA;
            PSEL       <= 1'b1;
            PENABLE    <= 1'b0;
            r_grant    <= w_winner;
          end
        end
        S_SETUP: PENABLE <= 1'b1;
        S_ACCESS: begin
          if (w_done) begin
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            r_last_grant <= r_grant;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

  // A requester that dropped PSEL mid-transfer gets nothing back; the downstream
  // transfer still runs to completion and its result is discarded.
  assign w_rsp0 = w_done && !r_grant && M0_PSEL;
  assign w_rsp1 = w_done &&  r_grant && M1_PSEL;

  assign M0_PREADY  = w_rsp0;
  assign M0_PSLVERR = w_rsp0 && (PSLVERR || w_timeout);
  assign M0_PRDATA  = (w_rsp0 && !w_timeout) ? PRDATA : '0;
  assign M1_PREADY  = w_rsp1;
  assign M1_PSLVERR = w_rsp1 && (PSLVERR || w_timeout);
  assign M1_PRDATA  = (w_rsp1 && !w_timeout) ? PRDATA : '0;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - scoreboard bench for apb_master_arbiter
`timescale 1ns/1ps

module tb_apb_master_arbiter;

  typedef struct {
    logic [1:0]  dec;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_dec   [2];
  logic [31:0] m_addr  [2];
  logic        m_write [2];
  logic        m_sel   [2];
  logic        m_en    [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic        m_ready [2];
  logic        m_err   [2];
  logic [1:0]  d_dec;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_write, d_sel, d_en, d_ready, d_err;

  int checks   = 0;
  int failures = 0;
  int fixed_wait = -1;
  int cwait = 0;

  req_t req_q [2][$];
  rsp_t rsp_q [2][$];
  int   win_q [$];
  bit   last_m = 1'b1;
  int   cur_w = 0;

  always #5 clk = ~clk;

  apb_master_arbiter dut (
    .PCLK(clk), .PRSTN(rst_n),
    .M0_DECODE2BIT(m_dec[0]), .M0_PADDR(m_addr[0]), .M0_PWRITE(m_write[0]),
    .M0_PSEL(m_sel[0]), .M0_PENABLE(m_en[0]), .M0_PWDATA(m_wdata[0]),
    .M0_PRDATA(m_rdata[0]), .M0_PREADY(m_ready[0]), .M0_PSLVERR(m_err[0]),
    .M1_DECODE2BIT(m_dec[1]), .M1_PADDR(m_addr[1]), .M1_PWRITE(m_write[1]),
    .M1_PSEL(m_sel[1]), .M1_PENABLE(m_en[1]), .M1_PWDATA(m_wdata[1]),
    .M1_PRDATA(m_rdata[1]), .M1_PREADY(m_ready[1]), .M1_PSLVERR(m_err[1]),
    .DECODE2BIT(d_dec), .PADDR(d_addr), .PWRITE(d_write), .PWDATA(d_wdata),
    .PSEL(d_sel), .PENABLE(d_en),
    .PRDATA(d_rdata), .PREADY(d_ready), .PSLVERR(d_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=no_event", nm);
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.dec  = 2'($urandom);
    r.addr = $urandom & 32'hFFFF_FFFC;
    r.wr   = 1'($urandom);
    r.wd   = $urandom;
    return r;
  endfunction

  task automatic drive_req(input int m, input req_t r);
    m_dec[m]   = r.dec;
    m_addr[m]  = r.addr;
    m_write[m] = r.wr;
    m_wdata[m] = r.wd;
    m_sel[m]   = 1'b1;
    m_en[m]    = 1'b0;
    req_q[m].push_back(r);
  endtask

  // Called at posedge+1; issues one APB transfer and waits (bounded) for PREADY.
  task automatic master_xfer(input int m, input int gap, input req_t r);
    int n;
    bit got;
    repeat (gap) begin @(posedge clk); #1; end
    drive_req(m, r);
    @(posedge clk); #1;
    m_en[m] = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      @(negedge clk);
      if (m_ready[m]) got = 1'b1;
      n++;
    end
    if (!got) begin
      failures++;
      checks++;
      $display("FAIL pready_timeout m%0d actual=0 required=1", m);
    end
    @(posedge clk); #1;
    m_sel[m] = 1'b0;
    m_en[m]  = 1'b0;
  endtask

  // Downstream completer: wait states chosen at SETUP, junk data while waiting.
  initial begin
    d_ready = 1'b0; d_rdata = '0; d_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        d_ready = 1'b0;
      end else if (d_sel && !d_en) begin
        cwait   = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        d_ready = 1'b0;
      end else if (d_sel && d_en) begin
        d_rdata = $urandom;
        if (cwait == 0) begin
          d_ready = 1'b1;
          d_err   = ($urandom_range(0, 3) == 0);
        end else begin
          cwait--;
          d_ready = 1'b0;
          d_err   = 1'($urandom);
        end
      end else begin
        d_ready = 1'b0;
      end
    end
  end

  // Reference model + scoreboard monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_m = 1'b1;
      win_q.delete();
      for (int m = 0; m < 2; m++) begin
        req_q[m].delete();
        rsp_q[m].delete();
      end
    end else begin
      if (!d_sel && (m_sel[0] || m_sel[1])) begin
        int w;
        if (m_sel[0] && m_sel[1]) w = last_m ? 0 : 1;
        else                      w = m_sel[1] ? 1 : 0;
        win_q.push_back(w);
        last_m = (w == 1);
      end
      if (d_sel && !d_en) begin
        if (win_q.size() == 0) fail_now("grant_unexpected");
        else begin
          cur_w = win_q.pop_front();
          if (req_q[cur_w].size() == 0) fail_now("grant_no_request");
          else begin
            req_t r;
            r = req_q[cur_w].pop_front();
            chk("ds_addr",  d_addr,  r.addr);
            chk("ds_wdata", d_wdata, r.wd);
            chk("ds_write", 32'(d_write), 32'(r.wr));
            chk("ds_dec",   32'(d_dec),   32'(r.dec));
          end
        end
      end
      if (d_sel && d_en && d_ready && m_sel[cur_w]) begin
        rsp_t s;
        s.rd  = d_rdata;
        s.err = d_err;
        rsp_q[cur_w].push_back(s);
      end
      for (int m = 0; m < 2; m++) begin
        if (m_ready[m]) begin
          if (rsp_q[m].size() == 0) fail_now($sformatf("pready_unexpected_m%0d", m));
          else begin
            rsp_t s;
            s = rsp_q[m].pop_front();
            chk($sformatf("prdata_m%0d", m),  m_rdata[m], s.rd);
            chk($sformatf("pslverr_m%0d", m), 32'(m_err[m]), 32'(s.err));
          end
        end else begin
          chk($sformatf("idle_prdata_m%0d", m),  m_rdata[m], 32'h0);
          chk($sformatf("idle_pslverr_m%0d", m), 32'(m_err[m]), 32'h0);
        end
        if (rsp_q[m].size() != 0) begin
          fail_now($sformatf("pready_missing_m%0d", m));
          rsp_q[m].delete();
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    req_t ra, rb;
    int n;
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_dec[m] = '0; m_addr[m] = '0; m_write[m] = 1'b0;
      m_sel[m] = 1'b0; m_en[m] = 1'b0; m_wdata[m] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_psel",    32'(d_sel), 0);
    chk("rst_penable", 32'(d_en), 0);
    chk("rst_paddr",   d_addr, 0);
    chk("rst_pwdata",  d_wdata, 0);
    chk("rst_dec",     32'(d_dec), 0);
    chk("rst_pwrite",  32'(d_write), 0);
    chk("rst_pready0", 32'(m_ready[0]), 0);
    chk("rst_pready1", 32'(m_ready[1]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // M0 lone zero-wait write: PSEL at +1, PENABLE and M0_PREADY at +2.
    fixed_wait = 0;
    ra.dec = 2'd1; ra.addr = 32'h0000_0008; ra.wr = 1'b1; ra.wd = 32'h0000_00A5;
    fork
      master_xfer(0, 0, ra);
      begin
        @(negedge clk); chk("lat_c0_psel", 32'(d_sel), 0);
        @(negedge clk); chk("lat_c1_psel", 32'({d_sel, d_en}), 32'b10);
        @(negedge clk); chk("lat_c2_penable", 32'(d_en), 1);
        chk("lat_c2_pready0", 32'(m_ready[0]), 1);
        chk("lat_c2_pready1", 32'(m_ready[1]), 0);
      end
    join

    // Randomized traffic from both requesters with random downstream wait states.
    fixed_wait = -1;
    fork
      for (int i = 0; i < 40; i++) master_xfer(0, int'($urandom_range(0, 2)), rand_req());
      for (int i = 0; i < 40; i++) master_xfer(1, int'($urandom_range(0, 2)), rand_req());
    join

    // Both held back-to-back: strict alternation checked by the model.
    fork
      for (int i = 0; i < 4; i++) master_xfer(0, 0, rand_req());
      for (int i = 0; i < 4; i++) master_xfer(1, 0, rand_req());
    join

    // M1 drops PSEL during ACCESS: transfer completes downstream, no PREADY returned.
    fixed_wait = 3;
    repeat (2) begin @(posedge clk); #1; end
    drive_req(1, rand_req());
    @(posedge clk); #1; m_en[1] = 1'b1;
    @(posedge clk); #1; m_sel[1] = 1'b0; m_en[1] = 1'b0;
    n = 0;
    while (d_sel && n < 20) begin @(negedge clk); n++; end
    chk("viol_downstream_done", 32'(d_sel), 0);

    // Reset in ACCESS drops everything asynchronously; afterwards M0 wins a tie.
    fixed_wait = 5;
    @(posedge clk); #1;
    drive_req(1, rand_req());
    @(posedge clk); #1; m_en[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #2;
    chk("pre_rst_access", 32'({d_sel, d_en}), 32'b11);
    rst_n = 1'b0;
    #1;
    chk("async_rst_psel",    32'(d_sel), 0);
    chk("async_rst_penable", 32'(d_en), 0);
    chk("async_rst_pready1", 32'(m_ready[1]), 0);
    @(posedge clk); #1;
    m_sel[1] = 1'b0; m_en[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fixed_wait = 0;
    ra = rand_req();
    rb = rand_req();
    rb.addr = ra.addr ^ 32'h0000_1000;
    fork
      master_xfer(0, 0, ra);
      master_xfer(1, 0, rb);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_tie_addr", d_addr, ra.addr);
      end
    join

    repeat (4) @(negedge clk);
    chk("end_win_q",  32'(win_q.size()), 0);
    chk("end_req_q0", 32'(req_q[0].size()), 0);
    chk("end_req_q1", 32'(req_q[1].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
